// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, func3 encodings and request legality check for the LSU
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    // Illegal encodings and misaligned halves/words never reach memory.
    function automatic logic req_is_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic illegal;
        logic misaligned;
        illegal    = we ? (f3[2] || f3[1:0] == 2'b11) : (f3[1:0] == 2'b11 || f3 == 3'b110);
        misaligned = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed byte/half of a read word and extends it
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  func3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (func3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'h0, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {16'h0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - single-outstanding load/store engine with req/gnt/rvalid memory port
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        func3_q, func3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       load_data;

    lsu_load_align u_align (
        .func3_i   (func3_q),
        .addr_lo_i (addr_q[1:0]),
        .rdata_i   (mem_rdata),
        .data_o    (load_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        func3_d = func3_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    func3_d = req_func3;
                    addr_d  = req_addr;
                    rdata_d = 32'h0;
                    cnt_d   = 8'h0;
                    be_d    = BE_WORD;
                    wdata_d = req_wdata;
                    if (req_we) begin
                        case (req_func3[1:0])
                            2'b00: begin
                                be_d    = 4'b0001 << req_addr[1:0];
                                wdata_d = {4{req_wdata[7:0]}};
                            end
                            2'b01: begin
                                be_d    = req_addr[1] ? BE_HALF_HI : BE_HALF_LO;
                                wdata_d = {2{req_wdata[15:0]}};
                            end
                            default: ;
                        endcase
                    end
                    err_d   = req_is_err(req_we, req_func3, req_addr[1:0]);
                    state_d = err_d ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    cnt_d   = 8'h0;
                    state_d = we_q ? RESP : WAIT;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = load_data;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'h0;
            we_q    <= 1'b0;
            func3_q <= 3'h0;
            addr_q  <= '0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            func3_q <= func3_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Response fields are only meaningful in the single RESP cycle.
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
    assign rsp_err   = rsp_valid & err_q;
    assign stall     = req_valid & ~rsp_valid;
    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - randomized scoreboard bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, stall, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    lsu_mem_ctrl #(.MAX_WAIT(MW), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .stall(stall), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;

    // memory behaviour for the current transaction
    int          g_dly, r_dly;
    bit          hold_gnt, hold_rv;
    logic [31:0] cur_word;
    bit          exp_acc = 0;
    logic [31:0] exp_addr, exp_wd;
    logic [3:0]  exp_be;
    logic        exp_we;
    int          stray_cnt = 0;

    int          req_run = 0, rv_cnt = 0, req_total = 0, stray_done = 0;
    bit          rv_pend = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                  input bit [31:0] wd, input bit [31:0] word,
                                  output bit err, output bit [31:0] rd,
                                  output bit [3:0] be, output bit [31:0] wdat);
        int size, off;
        bit legal;
        longint mask, val;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        off   = int'(addr % 4);
        err   = !legal || (off % size != 0);
        mask  = (64'd1 << (8 * size)) - 1;
        val   = (longint'(word) >> (8 * off)) & mask;
        if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
        rd    = (we || err) ? 32'h0 : val[31:0];
        be    = we ? 4'(((1 << size) - 1) << off) : 4'hF;
        wdat  = (size == 1) ? {24'h0, wd[7:0]} * 32'h01010101 :
                (size == 2) ? {16'h0, wd[15:0]} * 32'h00010001 : wd;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: grants after g_dly request cycles, returns read data r_dly cycles later.
    always @(negedge clk) begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (rv_pend) begin
            if (rv_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = cur_word;
                rv_pend    = 0;
            end else begin
                rv_cnt--;
            end
        end
        if (mem_req) begin
            req_total++;
            if (!exp_acc) begin
                chk("spurious_mem_req", 32'(mem_req), 32'h0);
            end else begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_be", 32'(mem_be), 32'(exp_be));
                chk("mem_we", 32'(mem_we), 32'(exp_we));
                if (exp_we) chk("mem_wdata", mem_wdata, exp_wd);
            end
            if (!hold_gnt && req_run >= g_dly) begin
                mem_gnt = 1'b1;
                if (!mem_we && !hold_rv) begin
                    rv_pend = 1;
                    rv_cnt  = r_dly;
                end
            end
            req_run++;
        end else begin
            req_run = 0;
            if (stray_done != stray_cnt) begin
                mem_gnt    = 1'b1;
                mem_rvalid = 1'b1;
                stray_done++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
            end else begin
                exp_t x;
                x = sb_q.pop_front();
                chk("rsp_rdata", rsp_rdata, x.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(x.err));
                chk("rsp_latency", 32'(cyc - x.acc), 32'(x.lat));
            end
        end
    end

    task automatic issue(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] wd, input bit [31:0] word,
                         input int gd, input int rdl, input bit wg, input bit wr);
        bit e, done, stall_ok, tmo;
        bit [31:0] rdx, wdx;
        bit [3:0] bex;
        exp_t x;
        int req0;
        model(we, f3, addr, wd, word, e, rdx, bex, wdx);
        tmo = !e && (wg || (wr && !we));
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wd;
        g_dly = gd; r_dly = rdl; hold_gnt = wg; hold_rv = wr; cur_word = word;
        exp_acc = !e; exp_addr = addr & 32'hFFFF_FFFC; exp_be = bex; exp_wd = wdx; exp_we = we;
        req0 = req_total;
        x.rdata = tmo ? 32'h0 : rdx;
        x.err   = e || tmo;
        x.lat   = e ? 1 : wg ? 1 + MW : we ? 2 + gd : wr ? 2 + gd + MW : 3 + gd + rdl;
        x.acc   = cyc;
        sb_q.push_back(x);
        @(negedge clk);
        chk("req_ready_accept", 32'(req_ready), 32'h1);
        done = 0;
        stall_ok = 1;
        for (int i = 0; i < 40 && !done; i++) begin
            if (i > 0) @(negedge clk);
            if (rsp_valid) begin
                done = 1;
                if (stall !== 1'b0) stall_ok = 0;
            end else if (stall !== 1'b1) begin
                stall_ok = 0;
            end
        end
        chk("rsp_within_budget", 32'(done), 32'h1);
        chk("stall_shape", 32'(stall_ok), 32'h1);
        chk("mem_req_cycles", 32'(req_total - req0), 32'(e ? 0 : wg ? MW : gd + 1));
        exp_acc = 0;
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'h0;
        req_addr = 32'h0; req_wdata = 32'h0;
        g_dly = 0; r_dly = 0; hold_gnt = 0; hold_rv = 0; cur_word = 32'h0;
        exp_addr = 32'h0; exp_wd = 32'h0; exp_be = 4'h0; exp_we = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {rsp_valid, rsp_err, mem_req, mem_we, mem_be, rsp_rdata | mem_wdata | mem_addr},
            36'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready_after_reset", 32'(req_ready), 32'h1);

        issue(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0);
        issue(0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 0, 0);
        issue(0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 0, 0);
        issue(0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 0, 0, 0, 0);
        issue(1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 0, 0, 0, 0);
        issue(0, 3'b001, 32'h101, 32'h0, 32'h12345678, 0, 0, 0, 0);
        issue(0, 3'b010, 32'h300, 32'h0, 32'h11111111, 0, 0, 1, 0);
        @(posedge clk); #1 req_valid = 1'b0;
        stray_cnt++;
        repeat (4) @(negedge clk);
        chk("idle_after_stray_gnt", 32'(req_ready), 32'h1);
        issue(0, 3'b101, 32'h306, 32'h0, 32'h22223333, 1, 0, 0, 1);

        // reset while a load waits for its read data, which then arrives after release
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h400;
        g_dly = 0; r_dly = 3; hold_gnt = 0; hold_rv = 0; cur_word = 32'hCAFEF00D;
        exp_acc = 1; exp_addr = 32'h400; exp_be = 4'hF; exp_we = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0; req_valid = 1'b0;
        #1 chk("mem_req_in_reset", 32'(mem_req), 32'h0);
        chk("rsp_valid_in_reset", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_acc = 0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) chk("req_ready_after_abort", 32'(req_ready), 32'h1);
            if (rsp_valid) seen++;
        end
        chk("no_rsp_after_abort", 32'(seen), 32'h0);

        for (int n = 0; n < 150; n++) begin
            bit we;
            bit [2:0] f3;
            we = 1'($urandom % 2);
            f3 = 3'($urandom % 8);
            if ($urandom % 4 != 0) f3 = we ? 3'($urandom % 3) : 3'($urandom % 3) | ($urandom % 2 == 0 ? 3'b000 : 3'b100);
            if (f3 == 3'b110 && !we) f3 = 3'b100;
            issue(we, f3, 32'h1000 + ($urandom % 4096), $urandom, $urandom,
                  int'($urandom % 3), int'($urandom % 3), ($urandom % 16) == 0, ($urandom % 16) == 0);
            if ($urandom % 3 == 0) begin
                @(posedge clk); #1 req_valid = 1'b0;
                repeat ($urandom % 3) @(posedge clk);
            end
        end

        @(posedge clk); #1 req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Downstream neighbour of the load/store mask generator. It takes one core load/store request at a time and runs a req/gnt/rvalid handshake to a multi-cycle data memory. It generates byte enables and lane-replicated store data, and returns aligned, sign- or zero-extended load data. While a request is in flight it stalls the single-cycle core.

Parameters:
MAX_WAIT, 16, cycles allowed in REQ or WAIT before a timeout error; legal range 2..255
ADDR_W, 32, address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  core has a load/store this cycle
req_we  in  1  1=store, 0=load
req_func3  in  3  inst[14:12]
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, rs2 value, right-aligned
req_ready  out  1  request accepted this cycle (state==IDLE)
stall  out  1  req_valid & ~rsp_valid; freezes core PC and regfile write
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data (0 for stores and errors)
rsp_err  out  1  misaligned, illegal func3 or timeout; qualified by rsp_valid
mem_req  out  1  memory request, held until mem_gnt
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  memory accepted request
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word

Behaviour:
- Reset: async on rst_n low; state=IDLE, timeout counter=0. rsp_valid, rsp_err, rsp_rdata, mem_req, mem_we, mem_be, mem_wdata, mem_addr all 0. req_ready=1 from the first cycle after release. Reset during REQ/WAIT aborts the transfer: mem_req drops immediately and a late mem_rvalid is ignored.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: on req_valid, latch we/func3/addr/wdata.
  - Error check: the request is an error if it is misaligned (half with addr[0]=1; word with addr[1:0]!=0) or has illegal func3 (loads: 011/110/111; stores: anything other than 000/001/010).
  - On error, go to RESP with err=1; no memory access.
  - Otherwise go to REQ.
- REQ: mem_req=1, with addr/we/be/wdata stable until gnt.
  - mem_gnt with store: go to RESP.
  - mem_gnt with load: go to WAIT.
- WAIT: on mem_rvalid, capture the aligned/extended data and go to RESP. mem_rvalid outside WAIT is ignored; mem_gnt outside REQ is ignored.
- Timeout: a counter clears on entry to REQ and WAIT and increments each cycle spent there. Reaching MAX_WAIT forces RESP with err=1 and rdata=0, and deasserts mem_req.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. The core presents its next request in the following IDLE cycle.
- Store byte enables and data:
  - SB: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: be=addr[1]?1100:0011, wdata={2{wdata[15:0]}}.
  - SW: be=1111, wdata unchanged.
  - Loads: be=1111, mem_we=0.
- Load extraction:
  - LB/LBU use lane addr[1:0].
  - LH/LHU use lane addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Latency, zero-wait memory (gnt same cycle as mem_req, rvalid the next cycle): accept at cycle 0, REQ at cycle 1, WAIT at cycle 2, RESP at cycle 3. Load = 4 cycles, store = 3 cycles, error = 2 cycles.

Decomposition:
- lsu_pkg holds:
  - func3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW)
  - state_t enum {IDLE, REQ, WAIT, RESP}
  - BE_WORD/BE_HALF_LO/BE_HALF_HI constants
- Sub-module lsu_load_align: purely combinational (func3, addr[1:0], mem_rdata -> rdata). It is instantiated once and unit-testable alone.

Test Plan:
- LW addr 0x100, zero-wait memory, mem_rdata 0xDEADBEEF -> mem_addr 0x100, be 1111; rsp_valid at cycle 3 with rdata 0xDEADBEEF, err 0; stall high cycles 0-2.
- LB addr 0x103, rdata 0x80FF1234 -> rdata 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x102 -> 0x000080FF.
- SB addr 0x201, wdata 0x000000A5 -> mem_be 0010, mem_wdata 0xA5A5A5A5, mem_we 1; rsp_valid at cycle 2.
- LH addr 0x101 -> no mem_req ever; rsp_valid at cycle 1 with err=1, rdata 0.
- Memory withholds mem_gnt with MAX_WAIT=4 -> mem_req high exactly 4 cycles, then rsp_err=1 and return to IDLE; a later mem_gnt is ignored.
- rst_n low during WAIT, with mem_rvalid arriving after release -> mem_req 0 immediately, no rsp_valid, req_ready=1 after release.
